// File: rtl/tmds_symbol_decoder_if.sv
// Channel-side bundle of the TMDS symbol decoder: raw deserializer words in,
// decoded symbols and alignment status out.
interface tmds_symbol_decoder_if;
  logic [9:0] raw_word;
  logic       raw_valid;
  logic       out_valid;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;
  logic       slip;

  // Source of raw words and consumer of decoded symbols.
  modport master (
    output raw_word, raw_valid,
    input  out_valid, de, ctrl, data, locked, offset, slip
  );

  // The decoder itself.
  modport slave (
    input  raw_word, raw_valid,
    output out_valid, de, ctrl, data, locked, offset, slip
  );
endinterface

// File: rtl/tmds_symbol_decoder.sv
// TMDS channel decoder: bit-slip word alignment on control-token runs,
// then 10b->8b data / 10b->2b control decode with one cycle of latency.
module tmds_symbol_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT   = 2048,
  parameter int CNT_W          = 13
) (
  input logic                  clk_pixel,
  input logic                  reset_n,
  tmds_symbol_decoder_if.slave bus
);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_e;

  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(CTRL_RUN - 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q;
  logic [9:0]       prev_q;
  logic [3:0]       offset_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] gap_q;
  logic             out_valid_q;
  logic             de_q;
  logic [1:0]       ctrl_q;
  logic [7:0]       data_q;
  logic             locked_q;
  logic             slip_q;

  logic [19:0] window;
  logic [19:0] shifted;
  logic [9:0]  sym;
  logic        is_ctrl;
  logic [1:0]  ctrl_bits;
  logic [7:0]  d;
  logic [7:0]  dec_data;
  logic [3:0]  offset_d;

  // Bit 0 of prev_q is the oldest bit on the wire; offset k takes the symbol
  // starting k bits before the current word.
  always_comb begin
    window  = {bus.raw_word, prev_q};
    shifted = window >> (5'd10 - {1'b0, offset_q});
    sym     = shifted[9:0];
  end

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_bits = 2'b00;
    unique case (sym)
      10'b1101010100: ctrl_bits = 2'b00;
      10'b0010101011: ctrl_bits = 2'b01;
      10'b0101010100: ctrl_bits = 2'b10;
      10'b1010101011: ctrl_bits = 2'b11;
      default:        is_ctrl   = 1'b0;
    endcase
  end

  always_comb begin
    d           = sym[9] ? ~sym[7:0] : sym[7:0];
    dec_data    = 8'h00;
    dec_data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  assign offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that existed before this edge.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      prev_q      <= '0;
      offset_q    <= '0;
      run_q       <= '0;
      wcnt_q      <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      de_q        <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      locked_q    <= 1'b0;
      slip_q      <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      if (!bus.raw_valid) begin
        out_valid_q <= 1'b0;
      end else begin
        prev_q      <= bus.raw_word;
        out_valid_q <= 1'b1;
        de_q        <= ~is_ctrl;
        ctrl_q      <= is_ctrl ? ctrl_bits : 2'b00;
        data_q      <= is_ctrl ? 8'h00 : dec_data;

        unique case (state_q)
          ST_SEARCH: begin
            // A completed run outranks a simultaneous timeout.
            if (is_ctrl && run_q == RUN_LAST) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              wcnt_q   <= '0;
              gap_q    <= '0;
            end else if (wcnt_q == SEARCH_LAST) begin
              offset_q <= offset_d;
              slip_q   <= 1'b1;
              run_q    <= '0;
              wcnt_q   <= '0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
              run_q  <= is_ctrl ? run_q + 1'b1 : '0;
            end
          end
          ST_LOCKED: begin
            if (is_ctrl) begin
              gap_q <= '0;
            end else if (gap_q == LOCK_LAST) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              offset_q <= offset_d;
              slip_q   <= 1'b1;
              gap_q    <= '0;
              run_q    <= '0;
              wcnt_q   <= '0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.de        = de_q;
  assign bus.ctrl      = ctrl_q;
  assign bus.data      = data_q;
  assign bus.locked    = locked_q;
  assign bus.offset    = offset_q;
  assign bus.slip      = slip_q;

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Directed bench for tmds_symbol_decoder: reset, aligned and misaligned lock,
// control mapping, stalls, lock loss and offset wrap.
module tb_tmds_symbol_decoder;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  // Encoder output for 0x00, 0xFF, 0x55 starting from zero disparity.
  localparam logic [9:0] SYM_00 = 10'h100;
  localparam logic [9:0] SYM_FF = 10'h200;
  localparam logic [9:0] SYM_55 = 10'h133;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b1;

  tmds_symbol_decoder_if bus ();

  tmds_symbol_decoder #(
    .CTRL_RUN      (8),
    .SEARCH_TIMEOUT(4096),
    .LOCK_TIMEOUT  (2048),
    .CNT_W         (13)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #20 clk_pixel = ~clk_pixel;

  int         checks = 0;
  int         errors = 0;
  int         slips  = 0;
  int         k      = 0;      // wire phase of symbol boundaries
  logic [9:0] pend   = TOK0;   // symbol whose tail is carried by the next word

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word of a continuous symbol stream at phase k; the decoder
  // then emits the previously queued symbol (pend).
  task automatic send(input logic [9:0] s);
    logic [19:0] pair;
    pair = {s, pend};
    @(negedge clk_pixel);
    bus.raw_word  = 10'(pair >> k);
    bus.raw_valid = 1'b1;
    pend = s;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle();
    @(negedge clk_pixel);
    bus.raw_valid = 1'b0;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_de"},        32'(bus.de),        0);
    check({tag, "_ctrl"},      32'(bus.ctrl),      0);
    check({tag, "_data"},      32'(bus.data),      0);
    check({tag, "_locked"},    32'(bus.locked),    0);
    check({tag, "_offset"},    32'(bus.offset),    0);
    check({tag, "_slip"},      32'(bus.slip),      0);
  endtask

  // Feeds 2049 data words after a token; the 2048th decoded data word drops lock.
  task automatic lock_loss(input string tag, input logic [3:0] exp_off);
    int pre;
    pre = slips;
    for (int i = 1; i <= 2049; i++) begin
      send(SYM_00);
      if (i == 2048) begin
        check({tag, "_held"}, 32'(bus.locked), 1);
        check({tag, "_no_slip"}, 32'(slips - pre), 0);
      end
      if (bus.slip) slips++;
    end
    check({tag, "_locked"}, 32'(bus.locked), 0);
    check({tag, "_slip"},   32'(bus.slip),   1);
    check({tag, "_offset"}, 32'(bus.offset), 32'(exp_off));
    idle();
    check({tag, "_slip_pulse"}, 32'(bus.slip), 0);
  endtask

  initial begin
    bus.raw_word  = '0;
    bus.raw_valid = 1'b0;

    // Power-on reset, asserted with no clock edge in between.
    #3 reset_n = 1'b0;
    #2 check_zero("rst");
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel) reset_n = 1'b1;

    // Aligned stream with stalls: lock after exactly 8 valid tokens.
    k = 0; pend = TOK0;
    send(TOK0);
    check("stall_ov1", 32'(bus.out_valid), 1);
    check("stall_de",  32'(bus.de),        0);
    idle();
    check("stall_ov0", 32'(bus.out_valid), 0);
    check("stall_hold_ctrl", 32'(bus.ctrl), 0);
    for (int n = 2; n <= 7; n++) begin
      send(TOK0);
      idle();
    end
    check("stall_pre_lock", 32'(bus.locked), 0);
    send(TOK0);
    check("stall_lock",   32'(bus.locked),    1);
    check("stall_ov_ret", 32'(bus.out_valid), 1);
    for (int n = 9; n <= 160; n++) begin
      send(TOK0);
      if (bus.slip) slips++;
    end
    check("blank_ctrl",  32'(bus.ctrl),   0);
    check("blank_de",    32'(bus.de),     0);
    check("blank_slips", 32'(slips),      0);
    send(SYM_00);
    send(SYM_FF);
    check("al_de_00", 32'(bus.de), 1);
    check("al_d00",   32'(bus.data), 32'h00);
    send(SYM_55);
    check("al_dFF",   32'(bus.data), 32'hFF);
    check("al_ctrl_on_data", 32'(bus.ctrl), 0);
    send(TOK0);
    check("al_d55",   32'(bus.data), 32'h55);
    send(TOK1);
    check("map_c00", 32'(bus.ctrl), 2'b00);
    check("map_c00_de", 32'(bus.de), 0);
    send(TOK2);
    check("map_c01", 32'(bus.ctrl), 2'b01);
    send(TOK3);
    check("map_c10", 32'(bus.ctrl), 2'b10);
    send(TOK0);
    check("map_c11", 32'(bus.ctrl), 2'b11);
    check("map_data0", 32'(bus.data), 0);
    check("map_locked", 32'(bus.locked), 1);

    // Mid-stream asynchronous reset, away from any clock edge.
    @(negedge clk_pixel);
    #5 reset_n = 1'b0;
    #1 check_zero("mid_rst");
    bus.raw_valid = 1'b0;
    @(negedge clk_pixel) reset_n = 1'b1;

    // Stream rotated by 3 bits: slips at words 4096, 8192, 12288, lock at 12296.
    k = 3; pend = TOK0; slips = 0;
    for (int i = 1; i <= 12296; i++) begin
      send(TOK0);
      if (bus.slip) begin
        slips++;
        check("mis_slip_word",   32'(i),          32'(slips * 4096));
        check("mis_slip_offset", 32'(bus.offset), 32'(slips));
      end
      if (i == 12295) check("mis_pre_lock", 32'(bus.locked), 0);
    end
    check("mis_lock",   32'(bus.locked), 1);
    check("mis_slips",  32'(slips),      3);
    check("mis_offset", 32'(bus.offset), 3);
    send(SYM_00);
    send(SYM_FF);
    check("mis_d00", 32'(bus.data), 32'h00);
    send(SYM_55);
    check("mis_dFF", 32'(bus.data), 32'hFF);
    send(TOK0);
    check("mis_d55", 32'(bus.data), 32'h55);
    send(TOK1);
    check("mis_c00", 32'(bus.ctrl), 2'b00);
    send(TOK2);
    check("mis_c01", 32'(bus.ctrl), 2'b01);
    send(TOK3);
    check("mis_c10", 32'(bus.ctrl), 2'b10);
    send(TOK0);
    check("mis_c11", 32'(bus.ctrl), 2'b11);
    check("mis_no_slip", 32'(slips), 3);

    // Lock loss at offset 3 moves to offset 4.
    lock_loss("loss3", 4'd4);

    // Keep searching on pure data: five timeouts step the offset to 9.
    slips = 0;
    for (int i = 1; i <= 5 * 4096; i++) begin
      send(SYM_00);
      if (bus.slip) slips++;
    end
    check("walk_slips",  32'(slips),      5);
    check("walk_slip",   32'(bus.slip),   1);
    check("walk_offset", 32'(bus.offset), 9);

    // Re-lock on a stream with phase 9, then lose lock to wrap the offset.
    k = 9;
    for (int i = 0; i < 64 && !bus.locked; i++) send(TOK0);
    check("o9_lock",   32'(bus.locked), 1);
    check("o9_offset", 32'(bus.offset), 9);
    send(TOK0);
    lock_loss("loss9", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_symbol_decoder.md
Name: tmds_symbol_decoder

Overview:
- TMDS receive-side channel decoder: the inverse of the HDMI text display's TMDS encoder.
- Accepts raw 10-bit parallel words from an external deserializer (one word per pixel clock) and finds symbol alignment by bit-slipping on control-token runs during blanking.
- Outputs decoded 8-bit video data or 2-bit control data with a data-enable flag.
- Sits one instance per TMDS channel (R, G, B) in the HDMI capture path, feeding a sync/pixel reconstructor.

Parameters:
- CTRL_RUN, 8, consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 4096, accepted words in SEARCH without a qualifying run before slipping one bit.
- LOCK_TIMEOUT, 2048, accepted words in LOCKED without any control token before dropping lock (must exceed 800-pixel line).
- CNT_W, 13, width of word counters (must hold max(SEARCH_TIMEOUT, LOCK_TIMEOUT)).

Ports:
- clk_pixel  input  1  pixel clock, 25 MHz; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- raw_word  input  10  deserialized word; bit 0 is the first bit on the wire.
- raw_valid  input  1  raw_word is valid this cycle; pipeline advances only when high.
- out_valid  output  1  registered; decoded outputs valid.
- de  output  1  1 = data symbol, 0 = control token.
- ctrl  output  2  control bits {CD1,CD0}; held at 0 when de=1.
- data  output  8  decoded video byte; held at 0 when de=0.
- locked  output  1  alignment FSM is in LOCKED.
- offset  output  4  current bit-slip offset, 0..9.
- slip  output  1  one-cycle pulse when offset changes.

Behaviour:
- Reset (async assert, sync release): all outputs, prev_word, counters and offset = 0; FSM = SEARCH.
- Alignment window:
  - On each raw_valid cycle, prev_word <= raw_word.
  - Window W = {raw_word, prev_word} (20 bits).
  - Symbol S = W[19-offset : 10-offset]. offset 0 gives S = raw_word; offset 9 gives S = {raw_word[0], prev_word[9:1]}.
- Control tokens, with ctrl mapping:
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
  - Any other S is a data symbol.
- Data decode:
  - d = S[9] ? ~S[7:0] : S[7:0].
  - data[0] = d[0].
  - For i = 1..7: data[i] = S[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Latency and output rules:
  - Outputs are registered, latency 1 cycle: a raw_valid at edge N produces de/ctrl/data/out_valid=1 after edge N+1.
  - raw_valid=0 -> out_valid <= 0; other outputs hold.
- FSM, SEARCH state:
  - run counts consecutive control tokens; it resets to 0 on any data symbol.
  - wcnt counts accepted words.
  - run reaches CTRL_RUN -> LOCKED (locked=1 on the same edge that registers the CTRL_RUN-th token); wcnt and run cleared.
  - Else wcnt reaches SEARCH_TIMEOUT-1 -> offset <= (offset==9) ? 0 : offset+1; slip=1 for that cycle; wcnt and run cleared; stay in SEARCH.
  - A run reaching CTRL_RUN on the same word as the timeout: lock wins, no slip.
- FSM, LOCKED state:
  - gap counts accepted words since the last control token; it clears on any control token.
  - gap reaches LOCK_TIMEOUT-1 -> SEARCH with offset advanced and slip pulse, counters cleared.
- Offset-change rules: offset takes effect for the next accepted word. The symbol after a slip can be garbage and is still output (out_valid=1); consumers qualify on locked.
- raw_valid=0 freezes all counters, offset and FSM.
- reset_n asserted mid-stream: immediate clear to reset state; realignment restarts from offset 0.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> all outputs 0, offset=0, locked=0 asynchronously, no clock needed.
- Aligned lock: feed 160 words of 1101010100 then encoder output of bytes 0x00, 0xFF, 0x55 at offset 0 -> locked=1 after the 8th token; then de=1, data=0x00, 0xFF, 0x55 one cycle after each input; during blanking ctrl=00, de=0.
- Misaligned stream: same stream rotated by 3 bits across words -> slip pulses at each SEARCH_TIMEOUT expiry; offset steps 0,1,2,... until the matching offset; lock follows; decoded data matches; no slip once locked.
- Control mapping: locked, feed the four tokens in order -> ctrl=00, 01, 10, 11 with de=0 and data=0.
- Lock loss: locked, feed 2048 data words with no token -> locked drops on the 2048th word, slip=1, offset increments; offset 9 wraps to 0.
- Stall: raw_valid toggles 1,0,1 mid-run -> out_valid follows with 1-cycle delay; run/gap counters are not advanced by invalid cycles; lock still achieved after exactly 8 valid tokens.
